// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial pattern detector family.
// State encodings stay plain localparams so legacy netlists keep their encoding.
package seq_det_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_CNT_W   = 8;

  // Length field must hold 0..MAX_LEN inclusive so out-of-range loads are visible.
  function automatic int unsigned calc_len_w(input int unsigned max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating up-counter with clear priority over increment.
// Reusable by any detector that reports a running event count.
module seq_match_cnt
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_d;

  always_comb begin
    w_count_d = r_count;
    if (i_clr) begin
      w_count_d = '0;
    end else if (i_inc && (r_count != CNT_SAT)) begin
      w_count_d = r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector: run-time pattern, length and overlap mode,
// registered one-cycle match pulse and a saturating match counter.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  localparam int unsigned LEN_W  = calc_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_in_valid,
  input  logic               i_in_bit,
  input  logic               i_cfg_load,
  input  logic [MAX_LEN-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_cfg_overlap,
  input  logic               i_count_clr,
  output logic               o_match,
  output logic [CNT_W-1:0]   o_match_count,
  output logic               o_cfg_err,
  output logic               o_active
);

  logic [0:0]         r_state;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_match;
  logic               r_cfg_err;
  logic               r_active;

  logic               w_len_ok;
  logic [0:0]         w_state_d;
  logic               w_shift;
  logic [MAX_LEN-1:0] w_hist_shift;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [LEN_W-1:0]   w_fill_d;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match_d;

  assign w_len_ok = (i_cfg_len != '0) && (i_cfg_len <= LEN_W'(MAX_LEN));

  always_comb begin
    w_state_d = r_state;
    if (i_cfg_load) begin
      w_state_d = w_len_ok ? ST_RUN : ST_IDLE;
    end
  end

  // A coincident config load takes the cycle; the stream bit is dropped.
  assign w_shift      = (r_state == ST_RUN) && i_in_valid && !i_cfg_load;
  assign w_hist_shift = {r_hist[MAX_LEN-2:0], i_in_bit};
  assign w_fill_inc   = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  // Compare on post-shift history; fill gates out stale bits left after a match.
  assign w_match_d = w_shift && (w_fill_inc >= r_len) &&
                     (((w_hist_shift ^ r_pat) & w_mask) == '0);

  assign w_fill_d = (w_match_d && !r_overlap) ? '0 : w_fill_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pat     <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
      r_cfg_err <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_active <= (w_state_d == ST_RUN);
      if (i_cfg_load) begin
        r_pat     <= i_cfg_pattern;
        r_len     <= i_cfg_len;
        r_overlap <= i_cfg_overlap;
        r_hist    <= '0;
        r_fill    <= '0;
        r_match   <= 1'b0;
        r_cfg_err <= !w_len_ok;
      end else begin
        r_match <= w_match_d;
        if (w_shift) begin
          r_hist <= w_hist_shift;
          r_fill <= w_fill_d;
        end
      end
    end
  end

  seq_match_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_match_d),
    .i_clr   (i_count_clr),
    .o_count (o_match_count)
  );

  assign o_match   = r_match;
  assign o_cfg_err = r_cfg_err;
  assign o_active  = r_active;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog: vector table for the streaming cases plus
// hand-written sequences for config errors, gaps, saturation and reset.
module tb_seq_det_prog;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_bit;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               count_clr;

  logic               match_a, cfg_err_a, active_a;
  logic [7:0]         count_a;
  logic               match_b, cfg_err_b, active_b;
  logic [1:0]         count_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_det_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_in_valid    (in_valid),
    .i_in_bit      (in_bit),
    .i_cfg_load    (cfg_load),
    .i_cfg_pattern (cfg_pattern),
    .i_cfg_len     (cfg_len),
    .i_cfg_overlap (cfg_overlap),
    .i_count_clr   (count_clr),
    .o_match       (match_a),
    .o_match_count (count_a),
    .o_cfg_err     (cfg_err_a),
    .o_active      (active_a)
  );

  seq_det_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (2)
  ) dut_c2 (
    .clk           (clk),
    .rst           (rst),
    .i_in_valid    (in_valid),
    .i_in_bit      (in_bit),
    .i_cfg_load    (cfg_load),
    .i_cfg_pattern (cfg_pattern),
    .i_cfg_len     (cfg_len),
    .i_cfg_overlap (cfg_overlap),
    .i_count_clr   (count_clr),
    .o_match       (match_b),
    .o_match_count (count_b),
    .o_cfg_err     (cfg_err_b),
    .o_active      (active_b)
  );

  typedef struct {
    logic             ld;
    logic [7:0]       pat;
    logic [LEN_W-1:0] len;
    logic             ovl;
    logic             v;
    logic             b;
    logic             clr;
    logic             em;
    logic [7:0]       ec;
    logic             ee;
    logic             ea;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ld, input logic [7:0] pat, input logic [LEN_W-1:0] len,
                              input logic ovl, input logic v, input logic b, input logic clr,
                              input logic em, input logic [7:0] ec, input logic ee,
                              input logic ea);
    vec_t x;
    x.ld = ld; x.pat = pat; x.len = len; x.ovl = ovl; x.v = v; x.b = b; x.clr = clr;
    x.em = em; x.ec = ec; x.ee = ee; x.ea = ea;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one clock worth of inputs, then sample 1 ns after the rising edge.
  task automatic cyc(input logic ld, input logic [7:0] pat, input logic [LEN_W-1:0] len,
                     input logic ovl, input logic v, input logic b, input logic clr);
    cfg_load = ld; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    in_valid = v; in_bit = b; count_clr = clr;
    @(posedge clk);
    #1;
    cfg_load = 1'b0; count_clr = 1'b0; in_valid = 1'b0;
  endtask

  task automatic bit_in(input logic v, input logic b);
    cyc(1'b0, cfg_pattern, cfg_len, cfg_overlap, v, b, 1'b0);
  endtask

  initial begin
    logic [6:0]  s1;
    logic [10:0] s2;
    logic [6:0]  m1;
    logic [10:0] m2;
    logic [7:0]  c1 [7];
    logic [7:0]  c2 [11];

    s1 = 7'b1011011;
    m1 = 7'b0001001;
    c1 = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
    s2 = 11'b10110111011;
    m2 = 11'b00010000001;
    c2 = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};

    // Test 1: 1011 len 4, overlapping
    vecs.push_back(mk(1, 8'h0B, 4'd4, 1, 0, 0, 0, 0, 8'd0, 0, 1));
    for (int i = 0; i < 7; i++) begin
      vecs.push_back(mk(0, 8'h0B, 4'd4, 1, 1, s1[6-i], 0, m1[6-i], c1[i], 0, 1));
    end
    // Test 2: same pattern, non-overlapping; clear the count alongside the load
    vecs.push_back(mk(1, 8'h0B, 4'd4, 0, 0, 0, 1, 0, 8'd0, 0, 1));
    for (int i = 0; i < 11; i++) begin
      vecs.push_back(mk(0, 8'h0B, 4'd4, 0, 1, s2[10-i], 0, m2[10-i], c2[i], 0, 1));
    end

    rst = 1'b1;
    cfg_load = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    in_valid = 0; in_bit = 0; count_clr = 0;
    #12;
    chk("reset_match", match_a, 0);
    chk("reset_count", count_a, 0);
    chk("reset_cfg_err", cfg_err_a, 0);
    chk("reset_active", active_a, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Before any config the detector ignores the stream
    bit_in(1, 1);
    chk("unconfig_match", match_a, 0);
    chk("unconfig_active", active_a, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].ld, vecs[i].pat, vecs[i].len, vecs[i].ovl, vecs[i].v, vecs[i].b, vecs[i].clr);
      chk($sformatf("vec%0d_match", i), match_a, vecs[i].em);
      chk($sformatf("vec%0d_count", i), count_a, vecs[i].ec);
      chk($sformatf("vec%0d_cfg_err", i), cfg_err_a, vecs[i].ee);
      chk($sformatf("vec%0d_active", i), active_a, vecs[i].ea);
    end

    // Test 3: illegal lengths
    cyc(1, 8'h05, 4'd0, 1, 0, 0, 0);
    chk("len0_cfg_err", cfg_err_a, 1);
    chk("len0_active", active_a, 0);
    chk("len0_count_kept", count_a, 2);
    cyc(1, 8'h05, 4'd9, 1, 0, 0, 0);
    chk("len9_cfg_err", cfg_err_a, 1);
    chk("len9_active", active_a, 0);
    for (int i = 0; i < 20; i++) begin
      bit_in(1, 1'($urandom_range(0, 1)));
      chk("idle_no_match", match_a, 0);
    end
    cyc(1, 8'h05, 4'd3, 1, 0, 0, 0);
    chk("len3_cfg_err", cfg_err_a, 0);
    chk("len3_active", active_a, 1);

    // Test 4: 101 with two idle cycles between valid bits
    bit_in(1, 1);
    bit_in(0, 0); bit_in(0, 1);
    chk("gap_no_match_a", match_a, 0);
    bit_in(1, 0);
    bit_in(0, 1); bit_in(0, 1);
    chk("gap_no_match_b", match_a, 0);
    bit_in(1, 1);
    chk("gap_match", match_a, 1);
    chk("gap_count", count_a, 3);
    bit_in(0, 1);
    chk("gap_pulse_one_cycle", match_a, 0);

    // Test 5: length 1 on the 2-bit counter, saturation then clear vs match
    cyc(1, 8'h01, 4'd1, 1, 0, 0, 1);
    chk("c2_cleared", count_b, 0);
    for (int i = 0; i < 5; i++) begin
      bit_in(1, 1);
      chk("len1_match", match_b, 1);
      chk("c2_sat_count", count_b, (i < 3) ? 2'(i + 1) : 2'd3);
    end
    bit_in(1, 0);
    chk("len1_zero_no_match", match_b, 0);
    cyc(0, 8'h01, 4'd1, 1, 1, 1, 1);
    chk("clr_wins_match", match_b, 1);
    chk("clr_wins_count", count_b, 0);

    // Test 6: reset mid-stream
    cyc(1, 8'h0B, 4'd4, 1, 0, 0, 0);
    bit_in(1, 1);
    bit_in(1, 0);
    rst = 1'b1;
    #2;
    chk("midrst_match", match_a, 0);
    chk("midrst_count", count_a, 0);
    chk("midrst_cfg_err", cfg_err_a, 0);
    chk("midrst_active", active_a, 0);
    rst = 1'b0;
    bit_in(1, 1);
    bit_in(1, 1);
    chk("postrst_no_match", match_a, 0);
    chk("postrst_active", active_a, 0);

    // Load and a valid bit together: the bit must not enter the history
    cyc(1, 8'h03, 4'd2, 1, 1, 1, 0);
    chk("ldvalid_match", match_a, 0);
    chk("ldvalid_active", active_a, 1);
    bit_in(1, 1);
    chk("ldvalid_fill_only_one", match_a, 0);
    bit_in(1, 1);
    chk("ldvalid_second_bit_match", match_a, 1);
    chk("ldvalid_count", count_a, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
